// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - hazard, instruction-memory and IF/ID signals of the fetch stage
interface if_fetch_stage_if;
  logic        PCwrite_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] branch_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        valid_o;

  modport master (
    input  PCwrite_i, stall_i, flush_i, branch_target_i, imem_ready_i, imem_rdata_i,
    output imem_req_o, imem_addr_o, pc_o, instr_o, valid_o
  );

  modport slave (
    output PCwrite_i, stall_i, flush_i, branch_target_i, imem_ready_i, imem_rdata_i,
    input  imem_req_o, imem_addr_o, pc_o, instr_o, valid_o
  );
endinterface

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch with variable-latency imem and IF/ID register
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk_i,
  input  logic               rst_i,
  if_fetch_stage_if.master   bus
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic        req;
  logic        accept;
  logic        done;
  logic [31:0] target;
  logic [31:0] next_addr;

  assign req       = (state_q == REQ) || (state_q == DROP);
  assign accept    = bus.PCwrite_i & ~bus.stall_i;
  assign done      = req & bus.imem_ready_i;
  assign target    = bus.branch_target_i & ~32'd3;
  assign next_addr = req_addr_q + 32'd4;

  assign bus.imem_req_o  = req;
  assign bus.imem_addr_o = req_addr_q;
  assign bus.pc_o        = ifid_pc_q;
  assign bus.instr_o     = ifid_instr_q;
  assign bus.valid_o     = ifid_valid_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    buf_d        = buf_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;

    // IF/ID turns into a bubble unless stalled; a delivery below overrides this
    if (!bus.stall_i || bus.flush_i) begin
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end

    if (bus.flush_i) begin
      pc_d = target;
      unique case (state_q)
        IDLE, HOLD: begin
          req_addr_d = target;
          state_d    = REQ;
        end
        REQ, DROP: begin
          // an outstanding request cannot be withdrawn; drain it in DROP
          if (done) begin
            req_addr_d = target;
            state_d    = REQ;
          end else begin
            state_d    = DROP;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          req_addr_d = pc_q;
          state_d    = REQ;
        end
        REQ: begin
          if (done && accept) begin
            ifid_pc_d    = req_addr_q;
            ifid_instr_d = bus.imem_rdata_i;
            ifid_valid_d = 1'b1;
            pc_d         = next_addr;
            req_addr_d   = next_addr;
          end else if (done) begin
            buf_d   = bus.imem_rdata_i;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (accept) begin
            ifid_pc_d    = req_addr_q;
            ifid_instr_d = buf_q;
            ifid_valid_d = 1'b1;
            pc_d         = next_addr;
            req_addr_d   = next_addr;
            state_d      = REQ;
          end
        end
        DROP: begin
          if (done) begin
            req_addr_d = pc_q;
            state_d    = REQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      buf_q        <= 32'd0;
      ifid_pc_q    <= 32'd0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      buf_q        <= buf_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

endmodule
